pipe_reg: RTL

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//
// Depth-stage valid/ready pipeline register with bubble collapse. Every stage
// holds a valid bit and a data register. A stage advances whenever some stage
// at or downstream of it is empty, or the consumer is taking the last stage.
// Empty slots are therefore squeezed out while the output is stalled, and a
// full pipe streams one item per cycle when the consumer is ready.
//
// Parameters
//   DataWidth  payload width in bits (>= 1)
//   Depth      number of register stages (>= 1)
//   ResetVal   value loaded into every data register on reset or flush
//
// Ports
//   clk_i      clock, all state updates on the rising edge
//   rst_ni     asynchronous active-low reset
//   flush_i    synchronous clear of every stage; input offered that cycle is dropped
//   valid_i    upstream payload valid
//   ready_o    block accepts a payload this cycle
//   d_i        upstream payload
//   valid_o    valid bit of the last stage
//   ready_i    downstream accepts the last stage this cycle
//   q_o        data register of the last stage
//   count_o    number of occupied stages (0 .. Depth)
// -----------------------------------------------------------------------------
module pipe_reg #(
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          Depth     = 2,
  parameter logic [DataWidth-1:0] ResetVal  = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DataWidth-1:0]         d_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [DataWidth-1:0]         q_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned CountWidth = $clog2(Depth + 1);

  // Stage state: v_q[k] / data_q[k], stage 0 on the input side.
  logic [Depth-1:0]     v_q;
  logic [DataWidth-1:0] data_q [Depth];

  // rdy[k] high means stage k loads from its upstream neighbour this cycle.
  // ready_i is the terminal term of the chain beyond the last stage.
  logic [Depth-1:0]     rdy;

  // Upstream source for each stage: stage k-1, or the input port for stage 0.
  logic [Depth-1:0]     v_prev;
  logic [DataWidth-1:0] data_prev [Depth];

  logic [CountWidth-1:0] count;

  // ---------------------------------------------------------------------------
  // Readiness chain, evaluated from the output side back to the input.
  // A stage can move when it is empty or when everything ahead of it moves;
  // equivalently, when ready_i is high or any stage at or after it is empty.
  // Carrying that "any slot free" term in a local accumulator keeps the chain
  // free of combinational self-references on the rdy vector.
  // ---------------------------------------------------------------------------
  always_comb begin : ready_chain
    logic slot_free;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    rdy       = '0;
    slot_free = ready_i;
    for (int k = int'(Depth) - 1; k >= 0; k--) begin
      slot_free = slot_free | ~v_q[k];
      rdy[k]    = slot_free;
    end
  end

  // ---------------------------------------------------------------------------
  // Upstream neighbour of each stage.
  // ---------------------------------------------------------------------------
  always_comb begin : prev_select
    v_prev       = '0;
    v_prev[0]    = valid_i;
    data_prev[0] = d_i;
    for (int k = 1; k < int'(Depth); k++) begin
      v_prev[k]    = v_q[k-1];
      data_prev[k] = data_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers. Flush outranks any transfer. A ready stage copies its
  // neighbour unconditionally, including an invalid one: that is how a bubble
  // travels downstream and how a departing item leaves its slot empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin : stage_regs
    if (!rst_ni) begin
      // NOTE: the data registers are reset as well as the valid bits, so q_o
      // reads ResetVal rather than stale payload whenever the pipe is cleared.
      v_q <= '0;
      for (int k = 0; k < int'(Depth); k++) begin
        data_q[k] <= ResetVal;
      end
    end else if (flush_i) begin
      v_q <= '0;
      for (int k = 0; k < int'(Depth); k++) begin
        data_q[k] <= ResetVal;
      end
    end else begin
      // NOTE: state uses non-blocking assignments so every stage samples its
      // neighbour's pre-edge value; blocking here would ripple one item through
      // the whole pipe in a single cycle.
      for (int k = 0; k < int'(Depth); k++) begin
        if (rdy[k]) begin
          v_q[k]    <= v_prev[k];
          data_q[k] <= data_prev[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy: population count of the valid bits.
  // ---------------------------------------------------------------------------
  always_comb begin : occupancy
    count = '0;
    for (int k = 0; k < int'(Depth); k++) begin
      count = count + CountWidth'(v_q[k]);
    end
  end

  assign ready_o = rdy[0] & ~flush_i;
  assign valid_o = v_q[Depth-1];
  assign q_o     = data_q[Depth-1];
  assign count_o = count;

  // ---------------------------------------------------------------------------
  // Interface invariants.
  // ---------------------------------------------------------------------------
  // A stalled output keeps its payload until the consumer takes it.
  stall_stable_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(q_o))
  );

  // Occupancy never exceeds the number of stages.
  count_range_a : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (32'(count_o) <= Depth)
  );

endmodule
